uart_fifo_arbiter: RTL
======================

# uart_fifo_arbiter

Round-robin arbiter and sequencer that shares one UART_FIFO frame transceiver between NUM_REQ on-chip requesters. It sits between the test-controller clients and UART_FIFO. For each transaction it latches the winner's TX frame, drives FIFO_IN and START_FLAG, and tracks the FIFO_RDY busy window. On completion it returns the frame received during the same full-duplex exchange, or a timeout error.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- FIFO_SIZE, 4, bytes per frame; must match UART_FIFO
- BITWIDTH, 8, bits per byte; must match UART_FIFO
- TIMEOUT_CYCLES, 'd1_000_000, max cycles per wait phase before abort (≥ 4)

- CLK_SYS  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  NUM_REQ  level request per requester; held until its DONE
- REQ_DATA  in  NUM_REQ*BITWIDTH*FIFO_SIZE  TX frames; requester i at slice [i*F +: F], F = BITWIDTH*FIFO_SIZE
- GRANT  out  NUM_REQ  one-hot owner of current transaction, 0 when idle
- DONE  out  1  one-cycle pulse at transaction end, owner still indicated by GRANT
- ERR  out  1  one-cycle pulse, coincident with DONE, on timeout
- RX_DATA  out  F  frame received in last successful transaction
- BUSY  out  1  high in every state except IDLE
- FIFO_IN  out  F  frame to UART_FIFO
- START_FLAG  out  1  launch request to UART_FIFO
- FIFO_RDY  in  1  UART_FIFO idle indicator

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE.
- IDLE: if |REQ and FIFO_RDY=1, pick the winner round-robin, searching from last_grant+1 with wrap at NUM_REQ-1→0. Register GRANT, latch that REQ_DATA slice into FIFO_IN, go to LAUNCH. If FIFO_RDY=0, because UART_FIFO is busy with an RX-initiated frame, no grant is issued.
- LAUNCH: START_FLAG←1, clear timeout counter, go to WAIT_BUSY.
- WAIT_BUSY: hold START_FLAG=1.
  - On FIFO_RDY=0: START_FLAG←0, clear counter, go to WAIT_DONE.
  - Otherwise increment the counter.
- WAIT_DONE: START_FLAG=0.
  - On FIFO_RDY=1: RX_DATA←FIFO_OUT-side frame presented on the FIFO_IN-paired receive bus. Note: UART_FIFO's FIFO_OUT is the receive bus; this port is named RX_DATA on the arbiter side and is registered from a FIFO_OUT input — see note below. Go to RELEASE.
  - Otherwise increment the counter.
- Note: the receive bus input is FIFO_OUT, in, width F, UART_FIFO received frame. It is sampled only on the WAIT_DONE→RELEASE transition.
- RELEASE: DONE=1 for one cycle. last_grant←index(GRANT). Next cycle: GRANT←0, go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 in WAIT_BUSY or WAIT_DONE, go to RELEASE with ERR=1. START_FLAG←0, RX_DATA unchanged, last_grant still advances.
- REQ deassertion mid-transaction is ignored; the transaction completes.
- A new REQ from the same requester in the DONE cycle is not served until the next arbitration, and then only after the other pending requesters.
- FIFO_IN is held stable from latch until the next grant.
- Counter width: $clog2(TIMEOUT_CYCLES); saturating is not required, because it clears on every phase entry.

## Timing
- Reset values:
  - GRANT=0, DONE=0, ERR=0, BUSY=0, START_FLAG=0
  - FIFO_IN=0, RX_DATA=0
  - state IDLE, last_grant=NUM_REQ-1, so requester 0 wins first
- Grant latency: REQ sampled high in cycle n → GRANT and FIFO_IN valid at n+1, START_FLAG high at n+2.
- START_FLAG stays high ≥ 2 cycles, because UART_FIFO double-syncs it, and until FIFO_RDY low is sampled.
- START_FLAG is low for the whole WAIT_DONE phase, which guarantees a clean rising edge on the next launch.
- Best case, with FIFO_RDY falling 3 cycles after START rises: GRANT to DONE = 5 + UART frame time.
- Back-to-back: DONE at cycle m → IDLE at m+1 → next GRANT at m+2 at the earliest.
- Async RST mid-transaction: all outputs return to reset values immediately. START_FLAG drops; UART_FIFO finishes its frame independently, and IDLE waits for FIFO_RDY=1 before re-granting.

## Test plan
- REQ=4'b0001, REQ_DATA[31:0]=32'hDEADBEEF, UART_FIFO model returns 32'h12345678 → GRANT=0001 one cycle later; FIFO_IN=DEADBEEF; START_FLAG pulse ≥ 2 cycles; DONE pulse; RX_DATA=12345678; ERR=0.
- REQ=4'b1111 held for 8 transactions → grant order 0,1,2,3,0,1,2,3, each DONE followed by a new GRANT exactly 2 cycles later.
- FIFO_RDY forced 0 while REQ=4'b0010 → no GRANT. Release FIFO_RDY → GRANT=0010 on the next cycle.
- TIMEOUT_CYCLES=16, FIFO_RDY stuck 1 after launch → DONE=ERR=1 at 16 cycles into WAIT_BUSY; START_FLAG=0; RX_DATA unchanged; next grant goes to the next requester.
- Assert RST during WAIT_DONE → outputs reset asynchronously. After release, with FIFO_RDY still 0, no grant; once FIFO_RDY=1, requester 0 is granted.
- REQ[2] dropped during WAIT_BUSY → transaction completes, DONE pulses, GRANT clears, and no re-grant to requester 2.

Source files
------------

// File: rtl/uart_fifo_arbiter_if.sv
// Requester-side and UART_FIFO-side signals of uart_fifo_arbiter.
// slave is the arbiter's view; master is the clients/UART_FIFO view.
interface uart_fifo_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int F       = 32
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*F-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic                 done;
    logic                 err;
    logic [F-1:0]         rx_data;
    logic                 busy;
    logic [F-1:0]         fifo_in;
    logic                 start_flag;
    logic                 fifo_rdy;
    logic [F-1:0]         fifo_out;

    modport slave (
        input  req, req_data, fifo_rdy, fifo_out,
        output grant, done, err, rx_data, busy, fifo_in, start_flag
    );

    modport master (
        output req, req_data, fifo_rdy, fifo_out,
        input  grant, done, err, rx_data, busy, fifo_in, start_flag
    );
endinterface

// File: rtl/uart_fifo_arbiter.sv
// Round-robin sharing of one UART_FIFO transceiver between NUM_REQ requesters.
// Each grant runs one full-duplex frame exchange and returns the RX frame or a timeout.
//
// state       | meaning
// S_IDLE      | no owner; arbitrate when a request is pending and UART_FIFO is idle
// S_LAUNCH    | owner granted, TX frame latched; START_FLAG rises next
// S_WAIT_BUSY | START_FLAG held high until UART_FIFO reports busy
// S_WAIT_DONE | START_FLAG low, waiting for UART_FIFO to return idle
// S_RELEASE   | DONE (and ERR on timeout) pulse; owner cleared next cycle
module uart_fifo_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FIFO_SIZE      = 4,
    parameter int BITWIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk_sys_i,
    input  logic               rst_i,
    uart_fifo_arbiter_if.slave bus_io
);
    localparam int F      = BITWIDTH * FIFO_SIZE;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [F-1:0]       fifo_in_q, fifo_in_d;
    logic [F-1:0]       rx_q, rx_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W1-1:0]  cand;
    logic [F-1:0]       sel_frame;

    // Search order starts just after the last owner and wraps at NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + IDX_W1'(k);
            if (cand >= IDX_W1'(NUM_REQ)) begin
                cand = cand - IDX_W1'(NUM_REQ);
            end
            if (!win_found && bus_io.req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_frame = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_frame = bus_io.req_data[i*F +: F];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fifo_in_d = fifo_in_q;
        rx_d      = rx_q;

        case (state_q)
            S_IDLE: begin
                if (win_found && bus_io.fifo_rdy) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    fifo_in_d        = sel_frame;
                    state_d          = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus_io.fifo_rdy) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    start_d = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (bus_io.fifo_rdy) begin
                    rx_d    = bus_io.fifo_out;
                    done_d  = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                last_d  = owner_q;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fifo_in_q <= '0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fifo_in_q <= fifo_in_d;
            rx_q      <= rx_d;
        end
    end

    assign bus_io.grant      = grant_q;
    assign bus_io.done       = done_q;
    assign bus_io.err        = err_q;
    assign bus_io.rx_data    = rx_q;
    assign bus_io.busy       = (state_q != S_IDLE);
    assign bus_io.fifo_in    = fifo_in_q;
    assign bus_io.start_flag = start_q;
endmodule
